inst_buffer: RTL and testbench
==============================

# inst_buffer

Decoupling FIFO between the IF stage and the ID stage of the 6-stage pipeline with branch prediction. Accepts fetched packets ({bp_info, inst, pc}) from IF under a valid/allowin handshake, holds up to DEPTH of them in order, and presents the oldest to ID. A single flush input discards all buffered packets on a pipeline redirect. IF stalls are decoupled from ID back-pressure.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- WIDTH, 100, packet width, equal to `FS_TO_DS_BUS_WD (36 bp_info + 32 inst + 32 pc)
- clk  input  1  system clock; all state changes on rising edge
- resetn  input  1  synchronous, active-low reset
- fs_to_ib_valid  input  1  IF offers a packet this cycle
- fs_to_ib_bus  input  WIDTH  packet from IF
- ib_allowin  output  1  buffer can accept a packet this cycle; drives IF's ds_allowin
- ib_to_ds_valid  output  1  head packet is valid for ID
- ib_to_ds_bus  output  WIDTH  head packet
- ds_allowin  input  1  ID accepts the head packet this cycle
- ib_flush  input  1  discard all contents (branch/exception redirect)
- ib_count  output  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH x WIDTH register array; write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping modulo DEPTH; separate count register, 0..DEPTH.
- push = fs_to_ib_valid && ib_allowin && !ib_flush; writes fs_to_ib_bus to mem[wp], and wp advances by 1.
- pop = ib_to_ds_valid && ds_allowin; rp advances by 1.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- ib_allowin = (count != DEPTH). It depends only on registered count, not on ds_allowin. This keeps IF off any combinational path from ID.
- ib_to_ds_valid = (count != 0) && !ib_flush.
- ib_to_ds_bus = mem[rp], read combinationally. When the buffer is empty its value is don't-care, but it must not be X after reset: the array is reset to 0.
- No bypass: a packet written in cycle N is visible at the head no earlier than cycle N+1.
- Flush: when ib_flush=1, the next-cycle state is wp=rp=0 and count=0. Any push or pop in that cycle is ignored, and ib_to_ds_valid is forced to 0 in that cycle.
- Order is strictly FIFO. No packet is duplicated, dropped (except by flush) or reordered.

## Timing
- Reset (resetn=0 at a clock edge): next cycle wp=0, rp=0, count=0, array=0. Outputs then read ib_to_ds_valid=0, ib_to_ds_bus=0, ib_allowin=1, ib_count=0. Reset takes priority over flush, push and pop.
- Latency from IF to ID is 1 cycle minimum (push at edge N, head valid during cycle N+1).
- Throughput is 1 packet per cycle when ID accepts every cycle, because push and pop proceed concurrently.
- Full (count=DEPTH): ib_allowin=0 even if ds_allowin=1 in the same cycle. A pop frees a slot visible the next cycle.
- Empty (count=0): ib_to_ds_valid=0. A push in the same cycle does not bypass.
- Pointer wrap: wp or rp at DEPTH-1 advances to 0.
- Reset asserted mid-operation discards contents exactly as flush does and also clears the array.
- ib_count reflects the registered count, updated one cycle after the push or pop.

## Test plan
- Reset then a single push (pc=0x1c000000): ib_allowin=1 throughout; ib_to_ds_valid rises exactly 1 cycle after the push; ib_to_ds_bus[31:0]=0x1c000000; ib_count goes 0->1->0 after the pop.
- Fill with ds_allowin=0, pushing pcs 0x1c000000..0x1c00000c: ib_count=4 and ib_allowin=0. A 5th offered packet is not accepted. Releasing ds_allowin pops the four in order; ib_allowin returns to 1 one cycle after the first pop.
- Streaming with fs_to_ib_valid=1 and ds_allowin=1 for 20 cycles and incrementing pcs: after the 1-cycle fill, one pop per cycle; ib_count stays at 1; pointers wrap at least four times with no loss or reorder.
- Flush while holding 3 packets and pushing a 4th: in the flush cycle ib_to_ds_valid=0; the next cycle ib_count=0 and ib_allowin=1; the pushed packet never appears at ID.
- resetn=0 for one cycle while 2 entries are held and push/pop are active: the next cycle shows count=0, ib_to_ds_valid=0 and ib_to_ds_bus=0; the following push behaves as after a power-on reset.
- Random valid/allowin/flush stimulus for 10k cycles against a reference queue model: the popped sequence equals the pushed sequence minus the flushed entries; ib_count never exceeds 4.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: IF->ID decoupling FIFO (fs_to_ib valid/bus in, ib_allowin out; ib_to_ds valid/bus out, ds_allowin in; ib_flush clears; ib_count occupancy)
module inst_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 100
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs_to_ib_valid,
  input  logic [WIDTH-1:0]           fs_to_ib_bus,
  output logic                       ib_allowin,
  output logic                       ib_to_ds_valid,
  output logic [WIDTH-1:0]           ib_to_ds_bus,
  input  logic                       ds_allowin,
  input  logic                       ib_flush,
  output logic [$clog2(DEPTH):0]     ib_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;
  assign ib_allowin     = count_q != (AW+1)'(DEPTH);
  assign ib_to_ds_valid = (count_q != '0) && !ib_flush;
  assign ib_to_ds_bus   = mem_q[rp_q];
  assign ib_count       = count_q;
  assign push           = fs_to_ib_valid && ib_allowin && !ib_flush;
  assign pop            = ib_to_ds_valid && ds_allowin;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = (push && wp_q == AW'(i)) ? fs_to_ib_bus : mem_q[i];
    wp_d    = ib_flush ? '0 : wp_q + AW'(push);
    rp_d    = ib_flush ? '0 : rp_q + AW'(pop);
    count_d = ib_flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: table-driven and model-based checks of inst_buffer
module tb_inst_buffer;
  localparam logic [31:0] B = 32'h1c000000;
  logic         clk = 0;
  logic         resetn;
  logic         fs_to_ib_valid;
  logic [99:0]  fs_to_ib_bus;
  logic         ib_allowin;
  logic         ib_to_ds_valid;
  logic [99:0]  ib_to_ds_bus;
  logic         ds_allowin;
  logic         ib_flush;
  logic [2:0]   ib_count;
  int           n = 0;
  int           miss = 0;
  inst_buffer #(.DEPTH(4), .WIDTH(100)) dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ib_valid(fs_to_ib_valid), .fs_to_ib_bus(fs_to_ib_bus), .ib_allowin(ib_allowin),
    .ib_to_ds_valid(ib_to_ds_valid), .ib_to_ds_bus(ib_to_ds_bus), .ds_allowin(ds_allowin),
    .ib_flush(ib_flush), .ib_count(ib_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        ea;
    logic        ev;
    logic [2:0]  ec;
    logic [31:0] eh;
  } vec_t;
  vec_t tbl [20];
  function automatic logic [99:0] pk(input logic [31:0] pc);
    return {4'h0, pc, ~pc, pc};
  endfunction
  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
    n++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    fs_to_ib_valid = v;
    fs_to_ib_bus   = pk(pc);
    ds_allowin     = rdy;
    ib_flush       = fl;
  endtask
  task automatic check(input logic ea, input logic ev, input logic [2:0] ec, input logic [31:0] eh);
    chk("allowin", 100'(ib_allowin), 100'(ea));
    chk("valid", 100'(ib_to_ds_valid), 100'(ev));
    chk("count", 100'(ib_count), 100'(ec));
    if (ev) chk("head", ib_to_ds_bus, pk(eh));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [99:0] q [$];
  initial begin
    tbl[0]  = '{1, B,         0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0,         1, 0, 1, 1, 1, B};
    tbl[2]  = '{0, 0,         0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, B,         0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, B+32'h04,  0, 0, 1, 1, 1, B};
    tbl[5]  = '{1, B+32'h08,  0, 0, 1, 1, 2, B};
    tbl[6]  = '{1, B+32'h0c,  0, 0, 1, 1, 3, B};
    tbl[7]  = '{1, B+32'h10,  1, 0, 0, 1, 4, B};
    tbl[8]  = '{0, 0,         1, 0, 1, 1, 3, B+32'h04};
    tbl[9]  = '{0, 0,         1, 0, 1, 1, 2, B+32'h08};
    tbl[10] = '{0, 0,         1, 0, 1, 1, 1, B+32'h0c};
    tbl[11] = '{0, 0,         0, 0, 1, 0, 0, 0};
    tbl[12] = '{1, B+32'h20,  0, 0, 1, 0, 0, 0};
    tbl[13] = '{1, B+32'h24,  0, 0, 1, 1, 1, B+32'h20};
    tbl[14] = '{1, B+32'h28,  0, 0, 1, 1, 2, B+32'h20};
    tbl[15] = '{1, B+32'h2c,  1, 1, 1, 0, 3, 0};
    tbl[16] = '{0, 0,         1, 0, 1, 0, 0, 0};
    tbl[17] = '{1, B+32'h30,  1, 0, 1, 0, 0, 0};
    tbl[18] = '{0, 0,         1, 0, 1, 1, 1, B+32'h30};
    tbl[19] = '{0, 0,         0, 0, 1, 0, 0, 0};
    resetn = 0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    resetn = 1;
    @(negedge clk);
    check(1, 0, 0, 0);
    chk("reset_bus", ib_to_ds_bus, '0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].rdy, tbl[i].fl);
      @(negedge clk);
      check(tbl[i].ea, tbl[i].ev, tbl[i].ec, tbl[i].eh);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1, B + 32'h100 + 32'(4 * k), 1, 0);
      @(negedge clk);
      if (k == 0) check(1, 0, 0, 0);
      else check(1, 1, 1, B + 32'h100 + 32'(4 * (k - 1)));
      tick();
    end
    drive(0, 0, 1, 0);
    @(negedge clk);
    check(1, 1, 1, B + 32'h100 + 32'(4 * 19));
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check(1, 0, 0, 0);
    tick();
    drive(1, B + 32'h40, 0, 0);
    tick();
    drive(1, B + 32'h44, 0, 0);
    tick();
    drive(1, B + 32'h48, 1, 0);
    resetn = 0;
    @(negedge clk);
    check(1, 1, 2, B + 32'h40);
    tick();
    resetn = 1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    check(1, 0, 0, 0);
    chk("rst_bus", ib_to_ds_bus, '0);
    tick();
    drive(1, B + 32'h50, 0, 0);
    @(negedge clk);
    check(1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    @(negedge clk);
    check(1, 1, 1, B + 32'h50);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk);
    check(1, 0, 0, 0);
    tick();
    for (int c = 0; c < 10000; c++) begin
      logic v, rdy, fl, ea, ev;
      logic [31:0] pc;
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      fl  = $urandom_range(0, 31) == 0;
      pc  = $urandom;
      drive(v, pc, rdy, fl);
      ea = q.size() != 4;
      ev = q.size() != 0 && !fl;
      @(negedge clk);
      chk("r_allowin", 100'(ib_allowin), 100'(ea));
      chk("r_valid", 100'(ib_to_ds_valid), 100'(ev));
      chk("r_count", 100'(ib_count), 100'(q.size()));
      if (ev) chk("r_head", ib_to_ds_bus, q[0]);
      if (fl) q.delete();
      else begin
        if (ev && rdy) void'(q.pop_front());
        if (v && ea) q.push_back(pk(pc));
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, miss);
    $finish;
  end
endmodule
